// File: rtl/ps2_pkg.sv
// ps2_pkg: types and constants shared by the PS/2 host transmitter and the
// keyboard receiver.
//   ps2_state_e      : transmitter FSM states
//   PS2_CMD_*        : host-to-device command bytes
//   PS2_RSP_*        : device-to-host response bytes
//   odd_parity()     : PS/2 frame parity bit for a data byte
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SHIFT,
        ACK,
        WAIT_IDLE
    } ps2_state_e;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;

    localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;
    localparam logic [7:0] PS2_RSP_RESEND   = 8'hFE;

    // The parity bit makes the total count of ones in data+parity odd.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake between a client and the PS/2 transmitter.
//   tx_data/tx_valid : byte and send request from the client
//   tx_ready         : transmitter idle, request is taken this cycle
//   busy             : frame in flight (gates the keyboard receiver)
//   tx_done/tx_error : one-cycle completion pulses (ACK / NACK or timeout)
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       tx_done;
    logic       tx_error;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, busy, tx_done, tx_error
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, busy, tx_done, tx_error
    );
endinterface

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: brings the raw PS2_CLK/PS2_DAT pad levels into the system
// clock domain and flags falling edges of the clock line.
//   clk_i/dat_i     : raw pad levels
//   clk_s_o/dat_s_o : synchronized levels (reset to 1, idle bus)
//   fall_o          : synchronized clock was 1 last cycle and is 0 now
module ps2_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clk_i,
    input  logic dat_i,
    output logic clk_s_o,
    output logic dat_s_o,
    output logic fall_o
);
    // Depth must be at least 2 for metastability protection.
    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] dat_sync_q;
    logic                   clk_prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], clk_i};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], dat_i};
            clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
        end
    end

    assign clk_s_o = clk_sync_q[SYNC_STAGES-1];
    assign dat_s_o = dat_sync_q[SYNC_STAGES-1];
    assign fall_o  = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter.
//   clk, reset             : system clock, async active-high reset
//   tx (slave)             : command handshake and completion pulses
//   ps2_clk_in/ps2_dat_in  : raw pad levels of PS2_CLK / PS2_DAT
//   ps2_clk_oe/ps2_dat_oe  : 1 = pull the line low, 0 = release
// Sequence: hold clock low, place start bit, release clock, then follow the
// device clock: bits 0..7, parity, stop, and sample the device ACK.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic         clk,
    input  logic         reset,
    ps2_host_tx_if.slave tx,
    input  logic         ps2_clk_in,
    input  logic         ps2_dat_in,
    output logic         ps2_clk_oe,
    output logic         ps2_dat_oe
);
    localparam int INH_W = $clog2(INHIBIT_CYCLES);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES);

    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE      = 3'(IDLE);
    localparam logic [2:0] S_INHIBIT   = 3'(INHIBIT);
    localparam logic [2:0] S_REQ       = 3'(REQ);
    localparam logic [2:0] S_SHIFT     = 3'(SHIFT);
    localparam logic [2:0] S_ACK       = 3'(ACK);
    localparam logic [2:0] S_WAIT_IDLE = 3'(WAIT_IDLE);

    logic clk_s, dat_s, fall;

    ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .reset   (reset),
        .clk_i   (ps2_clk_in),
        .dat_i   (ps2_dat_in),
        .clk_s_o (clk_s),
        .dat_s_o (dat_s),
        .fall_o  (fall)
    );

    logic [2:0]       state_q,   state_d;
    logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
    logic [TO_W-1:0]  to_cnt_q,  to_cnt_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       data_q,    data_d;
    logic             par_q,     par_d;
    logic             done_q,    done_d;
    logic             err_q,     err_d;
    logic             ready;
    logic [8:0]       frame_sh;

    // Ready drops during the pulse cycle so a new request is only taken
    // once the completion has been reported.
    assign ready       = (state_q == S_IDLE) & ~done_q & ~err_q;
    assign tx.tx_ready = ready;
    assign tx.busy     = ~ready;
    assign tx.tx_done  = done_q;
    assign tx.tx_error = err_q;

    // In SHIFT, bit_cnt 1..8 selects data bit 0..7 and 9 selects parity.
    assign frame_sh = {par_q, data_q} >> (bit_cnt_q - 4'd1);

    always_comb begin
        state_d   = state_q;
        inh_cnt_d = inh_cnt_q;
        to_cnt_d  = to_cnt_q;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        par_d     = par_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (tx.tx_valid && ready) begin
                    data_d    = tx.tx_data;
                    par_d     = odd_parity(tx.tx_data);
                    inh_cnt_d = '0;
                    state_d   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (inh_cnt_q == INH_LAST) begin
                    to_cnt_d  = '0;
                    bit_cnt_d = '0;
                    state_d   = S_REQ;
                end else begin
                    inh_cnt_d = inh_cnt_q + INH_W'(1);
                end
            end
            S_REQ, S_SHIFT, S_ACK, S_WAIT_IDLE: begin
                // Timeout wins over a fall in the same cycle.
                if (to_cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (state_q == S_WAIT_IDLE && clk_s && dat_s) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (fall) begin
                    to_cnt_d = '0;
                    if (bit_cnt_q != 4'd11)
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    case (state_q)
                        S_REQ:   state_d = S_SHIFT;
                        S_SHIFT: if (bit_cnt_q == 4'd9) state_d = S_ACK;
                        S_ACK: begin
                            if (dat_s) begin
                                err_d   = 1'b1;
                                state_d = S_IDLE;
                            end else begin
                                state_d = S_WAIT_IDLE;
                            end
                        end
                        default: ;
                    endcase
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            inh_cnt_q <= '0;
            to_cnt_q  <= '0;
            bit_cnt_q <= '0;
            data_q    <= '0;
            par_q     <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            inh_cnt_q <= inh_cnt_d;
            to_cnt_q  <= to_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
            par_q     <= par_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Line drives decode directly from the async-reset state, so a reset
    // releases both lines without waiting for a clock edge.
    always_comb begin
        ps2_clk_oe = (state_q == S_INHIBIT);
        ps2_dat_oe = 1'b0;
        case (state_q)
            S_INHIBIT: ps2_dat_oe = (inh_cnt_q == INH_LAST);
            S_REQ:     ps2_dat_oe = 1'b1;
            S_SHIFT:   ps2_dat_oe = ~frame_sh[0];
            default:   ps2_dat_oe = 1'b0;
        endcase
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH = 20;
    localparam int TMO = 400;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ps2_host_tx_if bus();

    // Open-drain bus: either side may pull low.
    logic dev_clk = 1'b1;
    logic dev_dat = 1'b1;
    logic clk_oe, dat_oe;
    logic clk_line, dat_line;
    assign clk_line = dev_clk & ~clk_oe;
    assign dat_line = dev_dat & ~dat_oe;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .tx         (bus),
        .ps2_clk_in (clk_line),
        .ps2_dat_in (dat_line),
        .ps2_clk_oe (clk_oe),
        .ps2_dat_oe (dat_oe)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_done = 0, n_err = 0, n_acc = 0;
    int done_at_acc = 0, last_err_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    // Odd parity from counting ones.
    function automatic logic model_par(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return (ones % 2) == 0;
    endfunction

    // Per-cycle rules, sampled mid-cycle after stimulus settles.
    initial begin
        logic prev_done = 1'b0, prev_err = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            check("busy_vs_ready", bus.busy, !bus.tx_ready);
            check("pulse_exclusive", bus.tx_done & bus.tx_error, 0);
            if (prev_done) check("done_one_cycle", bus.tx_done, 0);
            if (prev_err)  check("err_one_cycle", bus.tx_error, 0);
            if ((prev_done || prev_err) && !reset) check("ready_after_pulse", bus.tx_ready, 1);
            if (bus.tx_ready) check("idle_lines_released", {clk_oe, dat_oe}, 0);
            if (bus.tx_done) n_done++;
            if (bus.tx_error) begin n_err++; last_err_cyc = cyc; end
            if (bus.tx_valid && bus.tx_ready && !reset) begin n_acc++; done_at_acc = n_done; end
            prev_done = bus.tx_done;
            prev_err  = bus.tx_error;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [7:0] b);
        int g = 0;
        bit acc = 0;
        @(negedge clk);
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        do begin
            acc = bus.tx_ready;
            @(negedge clk);
            g++;
        end while (!acc && g < 1000);
        bus.tx_valid = 1'b0;
        if (!acc) check("send_accepted", 0, 1);
    endtask

    // Device: measure the request, clock 10 bits sampling on rising edges,
    // then clock the ACK bit. stop_after>0 abandons the frame after that fall.
    task automatic device(input int stop_after, input bit nack, output logic [9:0] bits,
                          output int inh_len, output bit start_ok, output int fall_cyc);
        int g = 0;
        bits = '1; inh_len = 0; start_ok = 0; fall_cyc = 0;
        while (clk_oe !== 1'b1 && g < 2000) begin @(negedge clk); g++; end
        if (g >= 2000) begin check("dev_request_seen", 0, 1); return; end
        while (clk_oe === 1'b1 && inh_len < 2000) begin
            start_ok = dat_oe;
            inh_len++;
            @(negedge clk);
        end
        start_ok = start_ok & dat_oe & ~dat_line;
        repeat (5) @(negedge clk);
        for (int k = 1; k <= 10; k++) begin
            dev_clk = 1'b0;
            fall_cyc = cyc;
            repeat (20) @(negedge clk);
            bits[k-1] = dat_line;
            dev_clk = 1'b1;
            if (k == stop_after) return;
            repeat (20) @(negedge clk);
        end
        repeat (5) @(negedge clk);
        if (!nack) dev_dat = 1'b0;
        repeat (5) @(negedge clk);
        dev_clk = 1'b0;
        repeat (20) @(negedge clk);
        dev_clk = 1'b1;
        repeat (5) @(negedge clk);
        dev_dat = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic frame(input logic [7:0] b, input bit nack, output logic [9:0] bits);
        int il, fc, g, d0, e0;
        bit so;
        d0 = n_done; e0 = n_err;
        fork
            send(b);
            device(0, nack, bits, il, so, fc);
        join
        g = 0;
        while (!bus.tx_ready && g < 200) begin @(negedge clk); g++; end
        repeat (3) @(negedge clk);
        check("frame_ready_back", bus.tx_ready, 1);
        check("frame_lines_released", {clk_oe, dat_oe}, 0);
        check("frame_byte", bits[7:0], b);
        check("frame_parity", bits[8], model_par(b));
        check("frame_stop", bits[9], 1);
        check("inhibit_len", il, INH);
        check("start_bit", so, 1);
        check("done_count", n_done - d0, nack ? 0 : 1);
        check("err_count", n_err - e0, nack ? 1 : 0);
    endtask

    initial begin
        logic [9:0] bits, bits2;
        int il, fc, g, d0, e0, a0, acc2_done;
        bit so;
        logic [7:0] rb;
        bit rn;

        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_ready", bus.tx_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_lines", {clk_oe, dat_oe}, 0);
        check("rst_pulses", {bus.tx_done, bus.tx_error}, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Clock activity while idle is ignored.
        d0 = n_done; e0 = n_err;
        repeat (3) begin
            dev_clk = 1'b0; repeat (10) @(negedge clk);
            dev_clk = 1'b1; repeat (10) @(negedge clk);
        end
        check("idle_fall_ready", bus.tx_ready, 1);
        check("idle_fall_pulses", (n_done - d0) + (n_err - e0), 0);

        // Directed commands with hand-derived frames.
        frame(PS2_CMD_SET_LEDS, 1'b0, bits);
        check("ED_bits_lsb_first", bits, 10'b1_1_11101101);
        frame(PS2_CMD_ENABLE, 1'b0, bits);
        check("F4_parity0", bits[8], 0);
        frame(8'h00, 1'b0, bits);
        check("00_parity1", bits[8], 1);

        // NACK on reset command.
        frame(PS2_CMD_RESET, 1'b1, bits);
        check("FF_parity1", bits[8], 1);

        // Device stops after fall 4: error 400 cycles after the fall is seen,
        // which lands 2 synchronizer + 1 register cycles after the pad edge.
        d0 = n_done; e0 = n_err;
        fork
            send(8'h3C);
            device(4, 1'b0, bits, il, so, fc);
        join
        g = 0;
        while (n_err == e0 && g < 1000) begin @(negedge clk); g++; end
        check("tmo_seen", n_err - e0, 1);
        check("tmo_delay", last_err_cyc - fc, TMO + 3);
        check("tmo_lines", {clk_oe, dat_oe}, 0);
        @(negedge clk);
        check("tmo_ready", bus.tx_ready, 1);
        check("tmo_no_done", n_done - d0, 0);
        check("tmo_partial_bits", bits[3:0], 4'hC);

        // Reset while bit 5 (a 0 for 0x1F) is driven.
        d0 = n_done; e0 = n_err;
        fork
            send(8'h1F);
            device(6, 1'b0, bits, il, so, fc);
        join
        @(negedge clk);
        #1;
        check("pre_rst_busy", bus.busy, 1);
        check("pre_rst_dat_low", dat_oe, 1);
        reset = 1'b1;
        #1;
        check("async_rst_lines", {clk_oe, dat_oe}, 0);
        check("async_rst_ready", bus.tx_ready, 1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_no_pulses", (n_done - d0) + (n_err - e0), 0);
        frame(PS2_CMD_SET_LEDS, 1'b0, bits);

        // tx_valid held high, data changed mid-frame.
        d0 = n_done; a0 = n_acc; acc2_done = -1;
        @(negedge clk);
        bus.tx_data  = 8'hA3;
        bus.tx_valid = 1'b1;
        fork
            begin
                device(0, 1'b0, bits, il, so, fc);
                device(0, 1'b0, bits2, il, so, fc);
            end
            begin
                g = 0;
                while (n_acc == a0 && g < 500) begin @(negedge clk); g++; end
                repeat (60) @(negedge clk);
                bus.tx_data = 8'h55;
                g = 0;
                while (n_acc < a0 + 2 && g < 3000) begin @(negedge clk); g++; end
                @(negedge clk);
                acc2_done = done_at_acc;
                bus.tx_valid = 1'b0;
            end
        join
        g = 0;
        while (!bus.tx_ready && g < 200) begin @(negedge clk); g++; end
        repeat (3) @(negedge clk);
        check("hold_first_byte", bits[7:0], 8'hA3);
        check("hold_second_byte", bits2[7:0], 8'h55);
        check("hold_accepts", n_acc - a0, 2);
        check("hold_second_after_done", acc2_done - d0, 1);
        check("hold_done_count", n_done - d0, 2);

        // Random commands, some NACKed.
        for (int i = 0; i < 6; i++) begin
            rb = 8'($urandom_range(0, 255));
            rn = ($urandom_range(0, 3) == 0);
            frame(rb, rn, bits);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
